// File: rtl/seq_shift_add_mult_if.sv
// Handshake and operand/result bundle for the sequential shift-add multiplier.
interface seq_shift_add_mult_if #(
  parameter int unsigned N = 8
);
  logic             start;
  logic             abort;
  logic [N-1:0]     a;
  logic [N-1:0]     b;
  logic             ready;
  logic             busy;
  logic             done;
  logic [2*N-1:0]   product;

  modport master (
    output start, abort, a, b,
    input  ready, busy, done, product
  );

  modport slave (
    input  start, abort, a, b,
    output ready, busy, done, product
  );
endinterface

// File: rtl/seq_shift_add_mult.sv
// Iterative unsigned N x N multiplier: one N-bit add with carry-out per cycle,
// N shift-add iterations, start/ready/done handshake with abort.
module seq_shift_add_mult #(
  parameter int unsigned N = 8
) (
  input logic                  clk,
  input logic                  rst,
  seq_shift_add_mult_if.slave  bus
);

  localparam int unsigned CntW = $clog2(N + 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [N-1:0]      m_q, m_d;
  logic [N-1:0]      acc_q, acc_d;
  logic [N-1:0]      q_q, q_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [2*N-1:0]    product_q, product_d;
  logic [N:0]        sum;

  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    acc_d     = acc_q;
    q_d       = q_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    // sum[N] is the adder carry; it lands in ACC[N-1] after the shift.
    sum = {1'b0, acc_q} + (q_q[0] ? {1'b0, m_q} : {(N + 1){1'b0}});

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          m_d     = bus.a;
          q_d     = bus.b;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        if (bus.abort) begin
          state_d = StIdle;
        end else begin
          acc_d = sum[N:1];
          q_d   = {sum[0], q_q[N-1:1]};
          cnt_d = cnt_q + CntW'(1);
          if (cnt_q == CntW'(N - 1)) begin
            state_d   = StDone;
            product_d = {sum[N:1], sum[0], q_q[N-1:1]};
          end
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      m_q       <= '0;
      acc_q     <= '0;
      q_q       <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      acc_q     <= acc_d;
      q_q       <= q_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  assign bus.ready   = (state_q == StIdle);
  assign bus.busy    = (state_q == StRun);
  assign bus.done    = (state_q == StDone);
  assign bus.product = product_q;

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// Scoreboard bench for seq_shift_add_mult: expected products queued at issue,
// compared when done pulses; handshake, abort and reset corner cases.
module tb_seq_shift_add_mult;

  localparam int unsigned N = 8;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;
  int   done_count = 0;
  logic [2*N-1:0] sb[$];

  seq_shift_add_mult_if #(.N(N)) bus ();

  seq_shift_add_mult #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard side: every done pulse must match the oldest queued product.
  always @(negedge clk) begin
    if (!rst && bus.done) begin
      done_count++;
      if (sb.size() == 0) check_eq("unexpected_done", 64'(bus.done), 64'd0);
      else check_eq("product", 64'(bus.product), 64'(sb.pop_front()));
    end
  end

  // Call at a negedge in IDLE; returns at the negedge of RUN cycle 1.
  task automatic issue(input logic [N-1:0] ia, input logic [N-1:0] ib, input bit expect_done);
    bus.a = ia;
    bus.b = ib;
    bus.start = 1'b1;
    if (expect_done) sb.push_back((2*N)'(ia) * (2*N)'(ib));
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Call at RUN cycle 1; returns at the negedge after DONE (IDLE).
  task automatic wait_done();
    int lat = 1;
    int nbusy = 0;
    while (!bus.done && lat < 40) begin
      if (bus.busy) nbusy++;
      @(negedge clk);
      lat++;
    end
    check_eq("latency", 64'(lat), 64'(N + 1));
    check_eq("busy_cycles", 64'(nbusy), 64'(N));
    @(negedge clk);
    check_eq("done_one_cycle", 64'(bus.done), 64'd0);
    check_eq("ready_after_done", 64'(bus.ready), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int dc;
    logic [N-1:0] ra, rb;
    rst = 1'b1;
    bus.start = 1'b1;
    bus.abort = 1'b0;
    bus.a = 8'd5;
    bus.b = 8'd5;
    repeat (3) begin
      @(negedge clk);
      check_eq("rst_ready", 64'(bus.ready), 64'd1);
      check_eq("rst_busy", 64'(bus.busy), 64'd0);
      check_eq("rst_done", 64'(bus.done), 64'd0);
      check_eq("rst_product", 64'(bus.product), 64'd0);
    end
    bus.start = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check_eq("idle_after_rst", 64'(bus.ready), 64'd1);

    // Basic op, then product must hold through IDLE.
    issue(8'd13, 8'd11, 1'b1);
    wait_done();
    repeat (20) @(negedge clk);
    check_eq("product_hold", 64'(bus.product), 64'h008F);

    issue(8'd255, 8'd255, 1'b1);
    wait_done();
    check_eq("product_ffxff", 64'(bus.product), 64'hFE01);
    issue(8'd0, 8'd200, 1'b1);
    wait_done();
    issue(8'd1, 8'd255, 1'b1);
    wait_done();
    check_eq("product_1xff", 64'(bus.product), 64'h00FF);

    for (int i = 0; i < 6; i++) begin
      ra = N'($urandom);
      rb = N'($urandom);
      issue(ra, rb, 1'b1);
      wait_done();
    end

    // start during RUN and DONE is ignored.
    dc = done_count;
    issue(8'd3, 8'd5, 1'b1);
    repeat (3) @(negedge clk);
    bus.a = 8'd7;
    bus.b = 8'd7;
    bus.start = 1'b1;
    check_eq("ready_in_run", 64'(bus.ready), 64'd0);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (N - 4) @(negedge clk);
    check_eq("done_at_n_plus_1", 64'(bus.done), 64'd1);
    check_eq("ready_in_done", 64'(bus.ready), 64'd0);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check_eq("ready_back", 64'(bus.ready), 64'd1);
    repeat (12) @(negedge clk);
    check_eq("single_done", 64'(done_count - dc), 64'd1);
    check_eq("product_3x5", 64'(bus.product), 64'h000F);

    // abort in RUN cycle 5.
    dc = done_count;
    issue(8'd100, 8'd100, 1'b0);
    repeat (4) @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check_eq("abort_ready", 64'(bus.ready), 64'd1);
    check_eq("abort_busy", 64'(bus.busy), 64'd0);
    repeat (12) @(negedge clk);
    check_eq("abort_no_done", 64'(done_count - dc), 64'd0);
    check_eq("abort_product", 64'(bus.product), 64'h000F);

    // abort coinciding with the final iteration wins.
    issue(8'd9, 8'd9, 1'b0);
    repeat (N - 1) @(negedge clk);
    check_eq("last_iter_busy", 64'(bus.busy), 64'd1);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check_eq("last_abort_done", 64'(bus.done), 64'd0);
    check_eq("last_abort_ready", 64'(bus.ready), 64'd1);
    check_eq("last_abort_product", 64'(bus.product), 64'h000F);

    // rst in RUN cycle 3.
    issue(8'd100, 8'd100, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("midrst_product", 64'(bus.product), 64'd0);
    check_eq("midrst_ready", 64'(bus.ready), 64'd1);
    check_eq("midrst_busy", 64'(bus.busy), 64'd0);
    issue(8'd200, 8'd3, 1'b1);
    wait_done();
    check_eq("product_200x3", 64'(bus.product), 64'h0258);

    check_eq("sb_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
